// File: rtl/sm_hex_pager_pkg.sv
// Shared types, sizes and page-select helpers for the hex display pager.
package sm_hex_pager_pkg;

   typedef enum logic {
      PAGE_LO = 1'b0,
      PAGE_HI = 1'b1
   } page_e;

   localparam int unsigned NIBBLES_TOTAL  = 8;
   localparam int unsigned NIBBLES_SHOWN  = 6;
   localparam int unsigned HI_PAGE_OFFSET = 2;
   localparam int unsigned DATA_W         = 4 * NIBBLES_TOTAL;
   localparam int unsigned DIGITS_W       = 4 * NIBBLES_SHOWN;

   // Six-nibble window of the probed word for the given page.
   function automatic logic [DIGITS_W-1:0] sel_digits(input logic [DATA_W-1:0] d, input page_e p);
      return (p == PAGE_HI) ? d[4*HI_PAGE_OFFSET +: DIGITS_W] : d[0 +: DIGITS_W];
   endfunction

   // Per-digit view of the eight-nibble change mask for the given page.
   function automatic logic [NIBBLES_SHOWN-1:0] sel_mask(input logic [NIBBLES_TOTAL-1:0] m, input page_e p);
      return (p == PAGE_HI) ? m[HI_PAGE_OFFSET +: NIBBLES_SHOWN] : m[0 +: NIBBLES_SHOWN];
   endfunction

endpackage

// File: rtl/sm_hex_pager_if.sv
// Probe-side inputs and display-side outputs of the hex pager.
interface sm_hex_pager_if import sm_hex_pager_pkg::*; ();

   logic [DATA_W-1:0]        data_in;
   logic                     page_key;
   logic [DIGITS_W-1:0]      digits;
   logic [NIBBLES_SHOWN-1:0] dp_n;
   logic                     page;
   logic [NIBBLES_SHOWN-1:0] changed;

   modport master (output data_in, page_key, input digits, dp_n, page, changed);
   modport slave  (input data_in, page_key, output digits, dp_n, page, changed);

endinterface

// File: rtl/sm_debounce.sv
// Two-flop synchronizer plus stability-count debouncer for a raw board key.
module sm_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_key,
   output logic o_stable
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic             r_stable;

   // Accept the synchronized level only after it has disagreed for the full window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync   <= '0;
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_key};
         if (r_sync[1] == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync[1];
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_stable = r_stable;

endmodule

// File: rtl/sm_hex_pager.sv
// Pages a 32-bit probe value onto six hex digits; blinks DPs of changed nibbles.
// Change tracking and blinking exist only when SM_HEX_PAGER_BLINK_EN is defined.
module sm_hex_pager import sm_hex_pager_pkg::*; #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned HOLD_CYCLES     = 25000000,
   parameter int unsigned BLINK_W         = 22
) (
   input logic            clk,
   input logic            rst,
   sm_hex_pager_if.slave  bus
);

   logic                     w_key_stable;
   logic                     w_press;
   logic                     r_key_q;
   page_e                    r_state;
   page_e                    w_state_next;
   logic [DIGITS_W-1:0]      r_digits;
   logic [NIBBLES_SHOWN-1:0] r_dp_n;
   logic [NIBBLES_SHOWN-1:0] w_dp_next;

   // Degenerate configurations; the block is intentionally empty.
   if (DEBOUNCE_CYCLES == 0 || HOLD_CYCLES == 0 || BLINK_W == 0) begin : g_cfg_invalid
   end

   sm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk      (clk),
      .rst      (rst),
      .i_key    (bus.page_key),
      .o_stable (w_key_stable)
   );

   assign w_press = w_key_stable & ~r_key_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= PAGE_LO;
         r_key_q  <= 1'b0;
         r_digits <= '0;
         r_dp_n   <= '1;
      end else begin
         r_state  <= w_state_next;
         r_key_q  <= w_key_stable;
         r_digits <= sel_digits(bus.data_in, r_state);
         r_dp_n   <= w_dp_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         PAGE_LO: if (w_press) w_state_next = PAGE_HI;
         PAGE_HI: if (w_press) w_state_next = PAGE_LO;
         default: w_state_next = PAGE_LO;
      endcase
   end

`ifdef SM_HEX_PAGER_BLINK_EN
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic [DATA_W-1:0]        r_data_q;
   logic                     r_primed;
   logic [NIBBLES_TOTAL-1:0] r_mask;
   logic [NIBBLES_TOTAL-1:0] w_diff;
   logic [HOLD_W-1:0]        r_hold;
   logic [BLINK_W-1:0]       r_blink;
   logic [BLINK_W-1:0]       w_blink_next;
   logic [NIBBLES_SHOWN-1:0] r_changed;
   logic [NIBBLES_SHOWN-1:0] w_chg_next;
   logic                     w_phase_next;

   // r_primed suppresses the bogus difference against the cleared data_q after reset.
   always_comb begin
      w_diff = '0;
      for (int k = 0; k < NIBBLES_TOTAL; k++) begin
         w_diff[k] = r_primed && (bus.data_in[4*k +: 4] != r_data_q[4*k +: 4]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_q  <= '0;
         r_primed  <= 1'b0;
         r_mask    <= '0;
         r_hold    <= '0;
         r_blink   <= '0;
         r_changed <= '0;
      end else begin
         r_data_q  <= bus.data_in;
         r_primed  <= 1'b1;
         r_blink   <= w_blink_next;
         r_changed <= w_chg_next;
         if (|w_diff) begin
            r_mask <= r_mask | w_diff;
            r_hold <= HOLD_LAST;
         end else if (r_hold != '0) begin
            r_hold <= r_hold - HOLD_W'(1);
         end else begin
            r_mask <= '0;
         end
      end
   end

   // DP register is fed the same next-state values as page/changed/phase so all stay aligned.
   always_comb begin
      w_chg_next   = sel_mask(r_mask, r_state);
      w_blink_next = r_blink + BLINK_W'(1);
      w_phase_next = w_blink_next[BLINK_W-1];
      w_dp_next    = ~{(w_state_next == PAGE_HI) | (w_chg_next[NIBBLES_SHOWN-1] & w_phase_next),
                       w_chg_next[NIBBLES_SHOWN-2:0] & {(NIBBLES_SHOWN-1){w_phase_next}}};
   end

   assign bus.changed = r_changed;
`else
   always_comb begin
      w_dp_next = {~(w_state_next == PAGE_HI), {(NIBBLES_SHOWN-1){1'b1}}};
   end

   assign bus.changed = '0;
`endif

   assign bus.digits = r_digits;
   assign bus.dp_n   = r_dp_n;
   assign bus.page   = (r_state == PAGE_HI);

endmodule

// File: tb/tb_sm_hex_pager.sv
// Directed bench for sm_hex_pager; expectations follow SM_HEX_PAGER_BLINK_EN if defined.
module tb_sm_hex_pager;

`ifdef SM_HEX_PAGER_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n;
   int   tests;
   int   fails;

   sm_hex_pager_if bus ();

   sm_hex_pager #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (8),
      .BLINK_W         (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running blink counter model: cycles since reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) n <= 0;
      else     n <= n + 1;
   end

   function automatic logic [5:0] ec(input logic [5:0] v);
      return BLINK ? v : 6'h00;
   endfunction

   function automatic logic [5:0] exp_dp(input logic [5:0] chg, input logic pg);
      logic ph;
      ph = n[1];
      return ~{pg | (chg[5] & ph), chg[4:0] & {5{ph}}};
   endfunction

   task automatic tick(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.data_in  = 32'h12345678;
      bus.page_key = 1'b0;
      tick(2);
      chk("rst_digits",  32'(bus.digits),  32'h0);
      chk("rst_dp_n",    32'(bus.dp_n),    32'h3F);
      chk("rst_page",    32'(bus.page),    32'h0);
      chk("rst_changed", 32'(bus.changed), 32'h0);

      rst = 1'b0;
      tick(1);
      chk("post_rst_digits", 32'(bus.digits), 32'h345678);
      tick(2);
      chk("post_rst_no_flag", 32'(bus.changed), 32'h0);

      // Reset in the middle of a debounce window.
      bus.page_key = 1'b1;
      tick(4);
      rst = 1'b1;
      bus.page_key = 1'b0;
      tick(1);
      chk("mid_deb_rst_page",   32'(bus.page),   32'h0);
      chk("mid_deb_rst_digits", 32'(bus.digits), 32'h0);
      chk("mid_deb_rst_dp_n",   32'(bus.dp_n),   32'h3F);
      rst = 1'b0;
      tick(1);
      chk("mid_deb_release_digits", 32'(bus.digits), 32'h345678);
      tick(10);
      chk("mid_deb_page_stays", 32'(bus.page), 32'h0);

      // Bounce: toggle every 2 cycles, never stable long enough.
      for (int i = 0; i < 10; i++) begin
         bus.page_key = ~bus.page_key;
         tick(2);
      end
      chk("bounce_page", 32'(bus.page), 32'h0);
      bus.page_key = 1'b0;
      tick(4);
      bus.page_key = 1'b1;
      tick(6);
      chk("press_page_early", 32'(bus.page), 32'h0);
      tick(1);
      chk("press_page_at7", 32'(bus.page), 32'h1);
      chk("press_dp5",      32'(bus.dp_n[5]), 32'h0);
      tick(1);
      chk("hi_digits", 32'(bus.digits), 32'h123456);

      // Release (ignored), then press again back to the low page.
      bus.page_key = 1'b0;
      tick(8);
      chk("release_no_toggle", 32'(bus.page), 32'h1);
      bus.page_key = 1'b1;
      tick(7);
      chk("back_lo_page", 32'(bus.page), 32'h0);
      tick(1);
      chk("back_lo_digits", 32'(bus.digits), 32'h345678);

      // Single nibble change.
      bus.data_in = 32'h12345679;
      tick(1);
      chk("chg_k1_changed", 32'(bus.changed), 32'h0);
      chk("chg_k1_digits",  32'(bus.digits),  32'h345679);
      tick(1);
      chk("chg_k2_changed", 32'(bus.changed), 32'(ec(6'b000001)));
      chk("chg_k2_dp",      32'(bus.dp_n),    32'(exp_dp(ec(6'b000001), 1'b0)));
      tick(1);
      chk("chg_k3_dp",      32'(bus.dp_n),    32'(exp_dp(ec(6'b000001), 1'b0)));
      tick(1);
      chk("chg_k4_dp",      32'(bus.dp_n),    32'(exp_dp(ec(6'b000001), 1'b0)));
      tick(5);
      chk("chg_k9_changed", 32'(bus.changed), 32'(ec(6'b000001)));
      tick(1);
      chk("chg_k10_clear",  32'(bus.changed), 32'h0);
      chk("chg_k10_dp",     32'(bus.dp_n[4:0]), 32'h1F);

      // Accumulate: nibble 0 then nibble 3 five cycles later.
      bus.data_in = 32'h12345678;
      tick(5);
      bus.data_in = 32'h1234A678;
      tick(2);
      chk("acc_k7_changed",  32'(bus.changed), 32'(ec(6'b001001)));
      tick(7);
      chk("acc_k14_changed", 32'(bus.changed), 32'(ec(6'b001001)));
      tick(1);
      chk("acc_k15_clear",   32'(bus.changed), 32'h0);

      // Reset in the middle of a hold.
      bus.data_in = 32'h12345678;
      tick(2);
      chk("mid_hold_changed", 32'(bus.changed), 32'(ec(6'b001000)));
      rst = 1'b1;
      tick(1);
      chk("mid_hold_rst_changed", 32'(bus.changed), 32'h0);
      rst = 1'b0;
      tick(2);
      chk("mid_hold_release_changed", 32'(bus.changed), 32'h0);

      // High-page mapping.
      bus.page_key = 1'b1;
      tick(7);
      chk("to_hi_page", 32'(bus.page), 32'h1);
      bus.page_key = 1'b0;
      bus.data_in  = 32'h92345678;
      tick(2);
      chk("hi_nib7_changed", 32'(bus.changed), 32'(ec(6'b100000)));
      chk("hi_nib7_dp",      32'(bus.dp_n),    32'(exp_dp(ec(6'b100000), 1'b1)));
      tick(8);
      chk("hi_nib7_clear", 32'(bus.changed), 32'h0);
      chk("hi_page_held",  32'(bus.page),    32'h1);

      // Key edge and data change in the same cycle.
      bus.page_key = 1'b1;
      bus.data_in  = 32'h12345778;
      tick(2);
      chk("hi_both_changed", 32'(bus.changed), 32'(ec(6'b100001)));
      tick(5);
      chk("sw_lo_page",        32'(bus.page),    32'h0);
      chk("sw_lo_changed_old", 32'(bus.changed), 32'(ec(6'b100001)));
      tick(1);
      chk("sw_lo_changed", 32'(bus.changed), 32'(ec(6'b000100)));
      chk("sw_lo_digits",  32'(bus.digits),  32'h345778);
      chk("sw_lo_dp",      32'(bus.dp_n),    32'(exp_dp(ec(6'b000100), 1'b0)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
